// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with ready-handshaked memory, optional BNE/ANDI, illegal-opcode trap and retired counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC, wait on mem_ready
// DECODE   | register read, branch target PC+(SignImm<<2) -> ALUOut
// MEMADR   | A+SignImm -> ALUOut for LW/SW
// MEMRD    | read data memory at ALUOut, wait on mem_ready
// MEMWB    | memory data -> rt
// MEMWR    | write data memory at ALUOut, wait on mem_ready
// EXEC     | R-type ALU operation on A,B
// ALUWB    | ALU result -> rd
// BRANCH   | compare A,B; conditional PC load from ALUOut
// IMMEX    | ADDI/ANDI ALU operation on A,SignImm
// IMMWB    | ALU result -> rt
// JUMP     | jump target -> PC
// TRAP     | illegal opcode seen; all strobes off until reset

module multicycle_ctrl #(
   parameter int CNT_W   = 16,
   parameter bit EN_BNE  = 1'b1,
   parameter bit EN_ANDI = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             memreq,
   output logic             iord,
   output logic             irwrite,
   output logic             pcwrite,
   output logic             branch,
   output logic             branch_ne,
   output logic [1:0]       pcsrc,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic             regdst,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             memwrite,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_IMMEX,
      S_IMMWB,
      S_JUMP,
      S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;
   logic             retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      memreq    = 1'b0;
      iord      = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      pcsrc     = 2'b00;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      regdst    = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;

      case (state_q)
         S_FETCH: begin
            memreq  = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_BNE:       state_d = EN_BNE ? S_BRANCH : S_TRAP;
               OP_ADDI:      state_d = S_IMMEX;
               OP_ANDI:      state_d = EN_ANDI ? S_IMMEX : S_TRAP;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            memreq = 1'b1;
            iord   = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            memreq   = 1'b1;
            iord     = 1'b1;
            memwrite = mem_ready;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            pcsrc     = 2'b01;
            branch    = (op == OP_BEQ);
            branch_ne = EN_BNE && (op == OP_BNE);
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = (EN_ANDI && (op == OP_ANDI)) ? 2'b11 : 2'b00;
            state_d = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      // a pending reset edge must not be preceded by any write strobe
      if (reset) begin
         memreq    = 1'b0;
         irwrite   = 1'b0;
         pcwrite   = 1'b0;
         branch    = 1'b0;
         branch_ne = 1'b0;
         regwrite  = 1'b0;
         memwrite  = 1'b0;
      end
   end

   always_comb begin
      retired_d = retired_q;
      if (retire && (retired_q != CNT_MAX)) retired_d = retired_q + CNT_ONE;
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   assign retired = retired_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (full decode / CNT_W=2 with BNE and ANDI
// disabled) share stimulus and are checked every cycle against an instruction/phase model.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                          OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                          OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_ADDI = 5,
                  C_ANDI = 6, C_J = 7, C_ILL = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b0;
   logic       mem_ready = 1'b0;

   logic       memreq[2], iord[2], irwrite[2], pcwrite[2], branch[2], branch_ne[2];
   logic [1:0] pcsrc[2], alusrcb[2], aluop[2];
   logic       alusrca[2], regdst[2], memtoreg[2], regwrite[2], memwrite[2], illegal[2];
   logic [15:0] ret_a;
   logic [1:0]  ret_b;
   logic [17:0] ctl[2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(16), .EN_BNE(1'b1), .EN_ANDI(1'b1)) dut_a (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .memreq(memreq[0]), .iord(iord[0]), .irwrite(irwrite[0]), .pcwrite(pcwrite[0]),
      .branch(branch[0]), .branch_ne(branch_ne[0]), .pcsrc(pcsrc[0]), .alusrca(alusrca[0]),
      .alusrcb(alusrcb[0]), .aluop(aluop[0]), .regdst(regdst[0]), .memtoreg(memtoreg[0]),
      .regwrite(regwrite[0]), .memwrite(memwrite[0]), .illegal(illegal[0]), .retired(ret_a));

   multicycle_ctrl #(.CNT_W(2), .EN_BNE(1'b0), .EN_ANDI(1'b0)) dut_b (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .memreq(memreq[1]), .iord(iord[1]), .irwrite(irwrite[1]), .pcwrite(pcwrite[1]),
      .branch(branch[1]), .branch_ne(branch_ne[1]), .pcsrc(pcsrc[1]), .alusrca(alusrca[1]),
      .alusrcb(alusrcb[1]), .aluop(aluop[1]), .regdst(regdst[1]), .memtoreg(memtoreg[1]),
      .regwrite(regwrite[1]), .memwrite(memwrite[1]), .illegal(illegal[1]), .retired(ret_b));

   for (genvar g = 0; g < 2; g++) begin : g_pack
      assign ctl[g] = {memreq[g], iord[g], irwrite[g], pcwrite[g], branch[g], branch_ne[g],
                       pcsrc[g], alusrca[g], alusrcb[g], aluop[g], regdst[g], memtoreg[g],
                       regwrite[g], memwrite[g], illegal[g]};
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
      end
   endtask

   // Model: each instruction is a class plus a phase index k (0 fetch, 1 decode, 2.. class-specific).
   int  m_k[2], m_cls[2], m_ret[2];
   bit  m_ill[2];
   bit  m_valid = 1'b0;
   int  m_max[2]     = '{65535, 3};
   bit  m_en_bne[2]  = '{1'b1, 1'b0};
   bit  m_en_andi[2] = '{1'b1, 1'b0};

   function automatic int decode(logic [5:0] o, bit eb, bit ea);
      case (o)
         OP_LW:   return C_LW;
         OP_SW:   return C_SW;
         OP_R:    return C_R;
         OP_BEQ:  return C_BEQ;
         OP_BNE:  return eb ? C_BNE : C_ILL;
         OP_ADDI: return C_ADDI;
         OP_ANDI: return ea ? C_ANDI : C_ILL;
         OP_J:    return C_J;
         default: return C_ILL;
      endcase
   endfunction

   function automatic int last_phase(int c);
      case (c)
         C_LW:               return 4;
         C_BEQ, C_BNE, C_J:  return 2;
         default:            return 3;
      endcase
   endfunction

   function automatic logic [17:0] exp_ctl(int c, int k, logic mr, logic rst, bit ill);
      logic mq = 0, io = 0, ir = 0, pw = 0, br = 0, bn = 0, aa = 0, rd = 0, mt = 0, rw = 0, mw = 0;
      logic [1:0] ps = 0, ab = 0, ao = 0;
      if (k == 0) begin
         mq = 1; ab = 2'b01; ir = mr; pw = mr;
      end else if (k == 1) begin
         ab = 2'b11;
      end else begin
         case (c)
            C_LW, C_SW: begin
               if (k == 2) begin aa = 1; ab = 2'b10; end
               else if (k == 3) begin mq = 1; io = 1; mw = (c == C_SW) && mr; end
               else begin rw = 1; mt = 1; end
            end
            C_R: begin
               if (k == 2) begin aa = 1; ao = 2'b10; end
               else begin rw = 1; rd = 1; end
            end
            C_BEQ, C_BNE: begin
               aa = 1; ao = 2'b01; ps = 2'b01; br = (c == C_BEQ); bn = (c == C_BNE);
            end
            C_ADDI, C_ANDI: begin
               if (k == 2) begin aa = 1; ab = 2'b10; ao = (c == C_ANDI) ? 2'b11 : 2'b00; end
               else rw = 1;
            end
            C_J: begin pw = 1; ps = 2'b10; end
            default: ;
         endcase
      end
      if (rst) begin mq = 0; ir = 0; pw = 0; br = 0; bn = 0; rw = 0; mw = 0; end
      return {mq, io, ir, pw, br, bn, ps, aa, ab, ao, rd, mt, rw, mw, logic'(ill)};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_k[i] = 0; m_ret[i] = 0; m_ill[i] = 0; m_valid = 1'b1;
         end else if (m_k[i] >= 2 && m_cls[i] == C_ILL) begin
            m_k[i] = m_k[i];
         end else if (m_k[i] == 0) begin
            if (mem_ready) m_k[i] = 1;
         end else if (m_k[i] == 1) begin
            m_cls[i] = decode(op, m_en_bne[i], m_en_andi[i]);
            m_k[i] = 2;
            if (m_cls[i] == C_ILL) m_ill[i] = 1;
         end else if (m_k[i] == 3 && (m_cls[i] == C_LW || m_cls[i] == C_SW) && !mem_ready) begin
            m_k[i] = 3;
         end else if (m_k[i] == last_phase(m_cls[i])) begin
            m_k[i] = 0;
            if (m_ret[i] < m_max[i]) m_ret[i]++;
         end else begin
            m_k[i]++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 2; i++)
            chk($sformatf("ctl[%0d] k=%0d cls=%0d", i, m_k[i], m_cls[i]), 32'(ctl[i]),
                32'(exp_ctl(m_cls[i], m_k[i], mem_ready, reset, m_ill[i])));
         chk("retired_a", 32'(ret_a), m_ret[0]);
         chk("retired_b", 32'(ret_b), m_ret[1]);
      end
   end

   task automatic drv(input logic r, input logic [5:0] o, input logic m);
      reset = r; op = o; mem_ready = m;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic r, input logic [5:0] o, input logic m);
      drv(r, o, m);
      tick();
   endtask

   task automatic run(input logic [5:0] o, input int n);
      for (int c = 0; c < n; c++) step(1'b0, o, 1'b1);
   endtask

   int exp_b_seq[5] = '{1, 2, 3, 3, 3};

   initial begin
      step(1'b1, OP_R, 1'b0);
      drv(1'b1, OP_R, 1'b1);
      chk("rst_memreq", 32'(memreq[0]), 0);
      chk("rst_irwrite", 32'(irwrite[0]), 0);
      tick();
      chk("rst_ret_a", 32'(ret_a), 0);
      chk("rst_ret_b", 32'(ret_b), 0);
      chk("rst_illegal", 32'(illegal[0]), 0);

      // LW, no stalls
      drv(1'b0, OP_LW, 1'b1);
      chk("lw_irwrite", 32'(irwrite[0]), 1);
      tick();
      run(OP_LW, 3);
      drv(1'b0, OP_LW, 1'b1);
      chk("lw_regwrite", 32'(regwrite[0]), 1);
      chk("lw_memtoreg", 32'(memtoreg[0]), 1);
      tick();
      chk("lw_retired", 32'(ret_a), 1);

      step(1'b1, OP_R, 1'b1);
      for (int n = 0; n < 5; n++) begin
         run(OP_J, 3);
         chk($sformatf("j%0d_ret_b", n), 32'(ret_b), exp_b_seq[n]);
         chk($sformatf("j%0d_ret_a", n), 32'(ret_a), n + 1);
      end

      // SW with three wait cycles in the memory write
      run(OP_SW, 3);
      for (int c = 0; c < 3; c++) begin
         drv(1'b0, OP_SW, 1'b0);
         chk("sw_wait_memwrite", 32'(memwrite[0]), 0);
         chk("sw_wait_memreq", 32'({memreq[0], iord[0]}), 32'b11);
         tick();
      end
      drv(1'b0, OP_SW, 1'b1);
      chk("sw_memwrite", 32'(memwrite[0]), 1);
      tick();
      chk("sw_retired", 32'(ret_a), 6);

      // R-type with a two-cycle fetch stall
      for (int c = 0; c < 2; c++) begin
         drv(1'b0, OP_R, 1'b0);
         chk("fetch_stall", 32'({irwrite[0], pcwrite[0]}), 0);
         tick();
      end
      drv(1'b0, OP_R, 1'b1);
      chk("fetch_go", 32'({irwrite[0], pcwrite[0]}), 32'b11);
      tick();
      run(OP_R, 3);
      chk("r_retired", 32'(ret_a), 7);

      run(OP_ADDI, 4);
      run(OP_BEQ, 2);
      drv(1'b0, OP_BEQ, 1'b1);
      chk("beq_branch", 32'({branch[0], branch_ne[0]}), 32'b10);
      tick();

      run(OP_BNE, 2);
      drv(1'b0, OP_BNE, 1'b1);
      chk("bne_branch", 32'({branch[0], branch_ne[0]}), 32'b01);
      chk("bne_aluop", 32'(aluop[0]), 32'b01);
      chk("bne_trap_b", 32'(illegal[1]), 1);
      tick();
      run(OP_J, 3);
      chk("trap_held_b", 32'(illegal[1]), 1);
      chk("bne_j_ret_a", 32'(ret_a), 11);

      // reset abandons a stalled LW in the memory read
      run(OP_LW, 3);
      step(1'b0, OP_LW, 1'b0);
      step(1'b0, OP_LW, 1'b0);
      step(1'b1, OP_LW, 1'b1);
      drv(1'b0, OP_LW, 1'b0);
      chk("midrst_ret_a", 32'(ret_a), 0);
      chk("midrst_ill_b", 32'(illegal[1]), 0);
      chk("midrst_writes", 32'({regwrite[0], memwrite[0]}), 0);
      tick();

      run(OP_ANDI, 2);
      drv(1'b0, OP_ANDI, 1'b1);
      chk("andi_aluop", 32'(aluop[0]), 32'b11);
      chk("andi_trap_b", 32'(illegal[1]), 1);
      tick();
      run(OP_ANDI, 1);
      chk("andi_retired", 32'(ret_a), 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle MIPS control unit; successor to the single-cycle main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake so variable-latency memory can stall the machine. Adds optional BNE/ANDI support, an illegal-opcode trap and a saturating retired-instruction counter; feeds the multicycle datapath.

Parameters:
CNT_W, 16, width of retired-instruction counter
EN_BNE, 1, 1 = decode BNE (op 000101); 0 = BNE is illegal
EN_ANDI, 1, 1 = decode ANDI (op 001100); 0 = ANDI is illegal

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode from instruction register
mem_ready  in  1  memory completes current request this cycle
memreq  out  1  memory access requested
iord  out  1  0 = PC address, 1 = ALUOut address
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC write
branch  out  1  conditional PC write on zero (BEQ)
branch_ne  out  1  conditional PC write on not-zero (BNE)
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
aluop  out  2  00 add, 01 sub, 10 funct, 11 and
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = memory data to register file
regwrite  out  1  register file write
memwrite  out  1  memory write
illegal  out  1  trap flag
retired  out  CNT_W  instructions completed, saturates at all-ones

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, TRAP. Encoding at implementer's choice.
- Reset (clk edge with reset=1): state <= FETCH, retired <= 0, illegal <= 0. While reset=1, all strobes (memreq, irwrite, pcwrite, branch, branch_ne, regwrite, memwrite) are 0 combinationally. Reset mid-instruction abandons it; no partial write is issued after the edge.
- Unlisted outputs are 0 in each state.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op: 100011/101011 MEMADR; 000000 EXEC; 000100 BRANCH; 000101 BRANCH if EN_BNE; 001000 IMMEX; 001100 IMMEX if EN_ANDI; 000010 JUMP; any other op TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: memreq=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: memreq=1, iord=1, memwrite=mem_ready. On mem_ready go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. branch=1 for BEQ, branch_ne=1 for BNE. Go to FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop=00 for ADDI, 11 for ANDI. Go to IMMWB.
- IMMWB: regwrite=1, regdst=0. Go to FETCH.
- JUMP: pcwrite=1, pcsrc=10. Go to FETCH.
- TRAP: illegal=1, sticky; all strobes 0. Stays until reset.
- op is sampled in DECODE, MEMADR and BRANCH/IMMEX. op is stable while the IR holds.
- retired increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, IMMWB or JUMP. It saturates at 2^CNT_W-1.
- CPI with mem_ready always 1: LW 5, SW 4, R-type 4, ADDI/ANDI 4, BEQ/BNE 3, J 3.

Test Plan:
- Reset mid-MEMRD, then release -> state FETCH, retired=0, memwrite/regwrite never pulse after the reset edge.
- LW op=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 cycles; regwrite=1 and memtoreg=1 in cycle 5; retired=1.
- SW with mem_ready low 3 cycles in MEMWR -> memreq=1, iord=1, memwrite=0 for 3 cycles, then memwrite=1 for 1 cycle; then FETCH.
- FETCH with mem_ready=0 for 2 cycles -> irwrite=pcwrite=0, state holds; on mem_ready=1 both pulse once, then DECODE.
- EN_BNE=1, op=000101 -> BRANCH with branch_ne=1, branch=0, aluop=01. EN_BNE=0, same op -> TRAP, illegal=1 held.
- CNT_W=2, 5 back-to-back J instructions -> retired sequence 1,2,3,3,3.
